// File: rtl/game_frame_ctrl.sv
// game_frame_ctrl
//   Per-frame game-state sequencer. Each VGA frame request runs one update:
//   move the platform, move the ball, resolve wall/platform/floor collisions,
//   then acknowledge so the renderer samples stable coordinates.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   frame_req  frame request, level, held until frame_ack
//   frame_ack  update done, coordinates stable (four-phase handshake)
//   btn_left   move platform left (level, pre-synchronised)
//   btn_right  move platform right
//   launch     release the held ball (sampled in BALL only)
//   ball_x     ball left column
//   ball_y     ball top row
//   plat_x     platform left column
//   ball_lost  one-cycle pulse when the ball reaches the floor
//   busy       high while PLAT, BALL or COLL is in progress
module game_frame_ctrl #(
   parameter int CW        = 10,
   parameter int SCR_W     = 640,
   parameter int SCR_H     = 480,
   parameter int BALL_SZ   = 8,
   parameter int PLAT_W    = 64,
   parameter int PLAT_Y    = 448,
   parameter int PLAT_STEP = 4,
   parameter int BALL_SPD  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_req,
   output logic          frame_ack,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          launch,
   output logic [CW-1:0] ball_x,
   output logic [CW-1:0] ball_y,
   output logic [CW-1:0] plat_x,
   output logic          ball_lost,
   output logic          busy
);

   typedef enum logic [2:0] {IDLE, PLAT, BALL, COLL, ACK} state_t;

   localparam logic [CW-1:0] PLAT_RST = CW'((SCR_W - PLAT_W) / 2);
   localparam logic [CW-1:0] PLAT_MAX = CW'(SCR_W - PLAT_W);
   localparam logic [CW-1:0] STEP     = CW'(PLAT_STEP);
   localparam logic [CW-1:0] CTR_OFS  = CW'(PLAT_W / 2 - BALL_SZ / 2);
   localparam logic [CW-1:0] HELD_Y   = CW'(PLAT_Y - BALL_SZ);
   localparam logic [CW-1:0] FLOOR_Y  = CW'(SCR_H - BALL_SZ);

   localparam logic signed [CW:0] X_MAX = (CW+1)'(SCR_W - BALL_SZ);
   localparam logic signed [CW:0] SPD   = (CW+1)'(BALL_SPD);
   localparam logic [CW:0] SZ_W  = (CW+1)'(BALL_SZ);
   localparam logic [CW:0] PW_W  = (CW+1)'(PLAT_W);
   localparam logic [CW:0] PY_LO = (CW+1)'(PLAT_Y);
   localparam logic [CW:0] PY_HI = (CW+1)'(PLAT_Y + BALL_SPD);

   state_t        state, state_nx;
   logic          ack_nx, lost_nx;
   logic [CW-1:0] plat_nx, bx_nx, by_nx;
   logic          vx_pos, vy_pos, held;   // direction bits: 1 = positive velocity
   logic          vx_nx, vy_nx, held_nx;

   // Candidate free-ball position, one bit wider and signed so that a step
   // past column/row 0 shows up as a negative value.
   logic signed [CW:0] next_x, next_y;
   logic [CW:0]        ball_bot, ball_rgt, plat_end;
   logic               plat_hit;

   assign next_x   = $signed({1'b0, ball_x}) + (vx_pos ? SPD : -SPD);
   assign next_y   = $signed({1'b0, ball_y}) + (vy_pos ? SPD : -SPD);
   assign ball_bot = {1'b0, ball_y} + SZ_W;
   assign ball_rgt = {1'b0, ball_x} + SZ_W;
   assign plat_end = {1'b0, plat_x} + PW_W;
   assign plat_hit = vy_pos && (ball_bot >= PY_LO) && (ball_bot <= PY_HI) &&
                     (ball_rgt > {1'b0, plat_x}) && ({1'b0, ball_x} < plat_end);

   assign busy = (state == PLAT) || (state == BALL) || (state == COLL);

   always_comb begin
      state_nx = state;
      ack_nx   = frame_ack;
      lost_nx  = 1'b0;
      plat_nx  = plat_x;
      bx_nx    = ball_x;
      by_nx    = ball_y;
      vx_nx    = vx_pos;
      vy_nx    = vy_pos;
      held_nx  = held;
      case (state)
         IDLE: if (frame_req) state_nx = PLAT;
         PLAT: begin
            state_nx = BALL;
            if (btn_left && !btn_right)
               plat_nx = (plat_x < STEP) ? '0 : plat_x - STEP;
            else if (btn_right && !btn_left)
               plat_nx = (plat_x > PLAT_MAX - STEP) ? PLAT_MAX : plat_x + STEP;
         end
         BALL: begin
            state_nx = COLL;
            if (held) begin
               bx_nx = plat_x + CTR_OFS;
               by_nx = HELD_Y;
               if (launch) begin
                  held_nx = 1'b0;
                  vx_nx   = 1'b1;
                  vy_nx   = 1'b0;
               end
            end else begin
               if (next_x[CW]) begin
                  bx_nx = '0;
                  vx_nx = 1'b1;
               end else if (next_x > X_MAX) begin
                  bx_nx = X_MAX[CW-1:0];
                  vx_nx = 1'b0;
               end else begin
                  bx_nx = next_x[CW-1:0];
               end
               if (next_y[CW]) begin
                  by_nx = '0;
                  vy_nx = 1'b1;
               end else begin
                  by_nx = next_y[CW-1:0];
               end
            end
         end
         COLL: begin
            state_nx = ACK;
            if (!held) begin
               if (plat_hit) begin
                  by_nx = HELD_Y;
                  vy_nx = 1'b0;
               end else if (ball_y >= FLOOR_Y) begin
                  lost_nx = 1'b1;
                  held_nx = 1'b1;
                  bx_nx   = plat_x + CTR_OFS;
                  by_nx   = HELD_Y;
                  vx_nx   = 1'b1;
                  vy_nx   = 1'b0;
               end
            end
         end
         ACK: begin
            // First ACK cycle raises ack unconditionally, so a request that
            // dropped mid-update still sees exactly one cycle of ack.
            if (!frame_ack) begin
               ack_nx = 1'b1;
            end else if (!frame_req) begin
               ack_nx   = 1'b0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         frame_ack <= 1'b0;
         ball_lost <= 1'b0;
         plat_x    <= PLAT_RST;
         ball_x    <= PLAT_RST + CTR_OFS;
         ball_y    <= HELD_Y;
         vx_pos    <= 1'b1;
         vy_pos    <= 1'b0;
         held      <= 1'b1;
      end else begin
         state     <= state_nx;
         frame_ack <= ack_nx;
         ball_lost <= lost_nx;
         plat_x    <= plat_nx;
         ball_x    <= bx_nx;
         ball_y    <= by_nx;
         vx_pos    <= vx_nx;
         vy_pos    <= vy_nx;
         held      <= held_nx;
      end
   end

endmodule

// File: doc/game_frame_ctrl.md
Name: game_frame_ctrl

Overview:
- Per-frame game-state sequencer for the board game top level. It sits between the VGA frame handshake and the object-position outputs.
- On each VGA frame request it does three things in order: moves the platform, moves the ball, and resolves wall, platform and floor collisions.
- It then acknowledges the request, so the renderer only ever samples stable coordinates.

Parameters:
- CW, 10, coordinate width in bits (unsigned).
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- BALL_SZ, 8, ball edge length in pixels.
- PLAT_W, 64, platform width in pixels.
- PLAT_Y, 448, platform top row (fixed).
- PLAT_STEP, 4, platform pixels moved per frame.
- BALL_SPD, 2, ball speed magnitude per axis per frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_req  in  1  VGA frame request, level, held until ack.
- frame_ack  out  1  update done; coordinates stable.
- btn_left  in  1  platform left (level, pre-synchronised).
- btn_right  in  1  platform right.
- launch  in  1  release held ball.
- ball_x  out  CW  ball left column.
- ball_y  out  CW  ball top row.
- plat_x  out  CW  platform left column.
- ball_lost  out  1  one-cycle pulse when ball reaches floor.
- busy  out  1  high in PLAT, BALL and COLL states.

Behaviour:
- Reset values (async, also mid-operation; any in-flight update is abandoned):
  - state=IDLE, frame_ack=0, busy=0, ball_lost=0.
  - plat_x=(SCR_W-PLAT_W)/2=288.
  - Ball held; ball_x=plat_x+PLAT_W/2-BALL_SZ/2=316, ball_y=PLAT_Y-BALL_SZ=440.
  - vx=+BALL_SPD, vy=-BALL_SPD.
- FSM: IDLE -> PLAT -> BALL -> COLL -> ACK -> IDLE.
  - IDLE leaves only when frame_req=1. PLAT, BALL and COLL each last one cycle.
  - ACK: frame_ack=1 while frame_req=1. When frame_req=0 is sampled, frame_ack=0 on that edge and state returns to IDLE.
- Latency: frame_req sampled high at edge N → frame_ack registered high at edge N+4.
- Handshake is four-phase; a new update never starts until req has returned low.
- If req drops during PLAT/BALL/COLL, the update still completes; ack is high for exactly one cycle.
- Outputs change only on PLAT/BALL/COLL edges and hold in IDLE/ACK.
- PLAT:
  - left-only: plat_x -= PLAT_STEP, saturating at 0.
  - right-only: plat_x += PLAT_STEP, saturating at SCR_W-PLAT_W (576).
  - both or neither: hold.
- BALL, held: ball_x/ball_y re-centred on the new plat_x.
  - If launch=1: ball becomes free with vx=+BALL_SPD, vy=-BALL_SPD.
  - Position does not move this frame.
- BALL, free: compute next = pos + v in CW+1-bit signed arithmetic.
  - next_x<0 → x=0, vx=+BALL_SPD.
  - next_x>SCR_W-BALL_SZ → x=SCR_W-BALL_SZ, vx=-BALL_SPD.
  - next_y<0 → y=0, vy=+BALL_SPD.
  - Otherwise pos=next.
  - X and Y reflections may occur in the same frame (corner).
- COLL, free ball only, priority order:
  1. Platform hit: vy>0, PLAT_Y ≤ ball_y+BALL_SZ ≤ PLAT_Y+BALL_SPD, ball_x+BALL_SZ>plat_x, and ball_x<plat_x+PLAT_W. Action: ball_y=PLAT_Y-BALL_SZ, vy=-BALL_SPD.
  2. Floor: ball_y ≥ SCR_H-BALL_SZ. Action: ball_lost pulses for one cycle (the COLL→ACK edge), ball returns to held, re-centred on plat_x, with reset velocities.
- A held ball never generates ball_lost or a platform hit.
- launch is ignored outside the BALL state.

Test Plan:
- Reset, then a single req → ack high 4 clocks after req sampled; outputs plat_x=288, ball_x=316, ball_y=440; ack falls one clock after req drops.
- btn_left held for 80 frames → plat_x reaches 0 after 72 frames and stays 0; held ball_x=28.
- Launch from reset, then 1 frame → free, ball_x=316, ball_y=440. Next frame → ball_x=318, ball_y=438.
- Free ball at x=631, y=1, vx=+2, vy=-2 → x=632, y=0, vx=-2, vy=+2 in one frame.
- Ball descending onto the platform, then a miss: in the descent frame, y=438, vx=-2, vy=+2, over plat_x=288 → y=440, vy=-2. Then move the platform away; the frame where y reaches ≥472 pulses ball_lost once, and the ball is held at the platform centre.
- Assert rst during BALL, then release → all outputs at reset values, ack=0, FSM idle; the next req completes normally.
